// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC operand issuer: FSM state, channel indices and beat indexing.
package mac_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NUM_HELD   = 3;

  localparam logic [IDX_W-1:0] CH_A     = 2'd0;
  localparam logic [IDX_W-1:0] CH_B     = 2'd1;
  localparam logic [IDX_W-1:0] CH_C     = 2'd2;
  localparam logic [IDX_W-1:0] CH_D     = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_e;

endpackage

// File: rtl/mac_issue_ch.sv
// One master valid/ready output channel: holds an operand and its pending bit until the MAC accepts it.
module mac_issue_ch
  import mac_pkg::*;
#(
  parameter int unsigned Data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [Data_width-1:0] data_i,
  input  logic                  ready_i,
  output logic [Data_width-1:0] data_o,
  output logic                  valid_o,
  output logic                  idle_next_c
);

  logic [Data_width-1:0] data_q, data_d;
  logic                  pending_q, pending_d;

  // Data is only loaded while the channel is idle, so it stays stable while pending.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_q & ~ready_i;
    if (load_i) begin
      data_d    = data_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = pending_q;
  assign idle_next_c = ~pending_d;

endmodule

// File: rtl/mac_operand_issuer.sv
// Collects serial A,B,C,D operand beats and issues each group on four independent valid/ready channels.
module mac_operand_issuer
  import mac_pkg::*;
#(
  parameter int unsigned Data_width = DATA_WIDTH,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_width-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [Data_width-1:0] m_a_data,
  output logic                  m_a_valid,
  input  logic                  m_a_ready,
  output logic [Data_width-1:0] m_b_data,
  output logic                  m_b_valid,
  input  logic                  m_b_ready,
  output logic [Data_width-1:0] m_c_data,
  output logic                  m_c_valid,
  input  logic                  m_c_ready,
  output logic [Data_width-1:0] m_d_data,
  output logic                  m_d_valid,
  input  logic                  m_d_ready,
  output logic                  err_framing,
  output logic [CNT_W-1:0]      grp_count
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [Data_width-1:0] op_q [NUM_HELD];
  logic [Data_width-1:0] op_d [NUM_HELD];
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      grp_q, grp_d;
  logic                  load_c;
  logic                  accept_c;

  logic [NUM_CH-1:0]     ch_ready;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH-1:0]     ch_idle_next;
  logic [Data_width-1:0] ch_data [NUM_CH];

  assign s_ready  = (state_q == COLLECT);
  assign accept_c = s_valid & s_ready;
  assign ch_ready = {m_d_ready, m_c_ready, m_b_ready, m_a_ready};

  // Collect FSM: s_last must coincide exactly with the D beat, otherwise the group is dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    grp_d   = grp_q;
    load_c  = 1'b0;
    op_d    = op_q;
    case (state_q)
      COLLECT: begin
        if (accept_c) begin
          if (s_last != (idx_q == LAST_IDX)) begin
            err_d = 1'b1;
            idx_d = '0;
          end else if (s_last) begin
            idx_d   = '0;
            load_c  = 1'b1;
            state_d = ISSUE;
          end else begin
            for (int unsigned i = 0; i < NUM_HELD; i++) begin
              if (idx_q == IDX_W'(i)) op_d[i] = s_data;
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        if (&ch_idle_next) begin
          state_d = COLLECT;
          grp_d   = grp_q + CNT_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      err_q   <= 1'b0;
      grp_q   <= '0;
      for (int unsigned i = 0; i < NUM_HELD; i++) op_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      grp_q   <= grp_d;
      op_q    <= op_d;
    end
  end

  // The D operand is taken straight from the bus on the beat that completes the group.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [Data_width-1:0] load_data;
    if (g == NUM_CH - 1) begin : g_direct
      assign load_data = s_data;
    end else begin : g_held
      assign load_data = op_q[g];
    end
    mac_issue_ch #(.Data_width(Data_width)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_c),
      .data_i      (load_data),
      .ready_i     (ch_ready[g]),
      .data_o      (ch_data[g]),
      .valid_o     (ch_valid[g]),
      .idle_next_c (ch_idle_next[g])
    );
  end

  assign m_a_data    = ch_data[CH_A];
  assign m_b_data    = ch_data[CH_B];
  assign m_c_data    = ch_data[CH_C];
  assign m_d_data    = ch_data[CH_D];
  assign m_a_valid   = ch_valid[CH_A];
  assign m_b_valid   = ch_valid[CH_B];
  assign m_c_valid   = ch_valid[CH_C];
  assign m_d_valid   = ch_valid[CH_D];
  assign err_framing = err_q;
  assign grp_count   = grp_q;

endmodule

// File: tb/tb_mac_operand_issuer.sv
// Directed self-checking bench for mac_operand_issuer: framing, fork handshakes, reset and counter wrap.
module tb_mac_operand_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_a_data, m_b_data, m_c_data, m_d_data;
  logic       m_a_valid, m_b_valid, m_c_valid, m_d_valid;
  logic       m_a_ready = 1'b1, m_b_ready = 1'b1, m_c_ready = 1'b1, m_d_ready = 1'b1;
  logic       err_framing;
  logic [7:0] grp_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mac_operand_issuer #(.Data_width(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_b_data(m_b_data), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_c_data(m_c_data), .m_c_valid(m_c_valid), .m_c_ready(m_c_ready),
    .m_d_data(m_d_data), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .err_framing(err_framing), .grp_count(grp_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] valids();
    return {m_a_valid, m_b_valid, m_c_valid, m_d_valid};
  endfunction

  function automatic logic [31:0] datas();
    return {m_a_data, m_b_data, m_c_data, m_d_data};
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    {m_a_ready, m_b_ready, m_c_ready, m_d_ready} = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents one beat at a negedge and returns at the negedge after it was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int waited = 0;
    while (s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got=%b exp=1", s_ready);
    end
    s_data = d; s_last = last; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL reset_valids got=%b exp=0000", valids()); end
    checks++; if (datas() !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", datas()); end
    checks++; if (grp_count !== 8'd0) begin failures++; $display("FAIL reset_grp got=%0d exp=0", grp_count); end
    checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_framing); end
  endtask

  task automatic test_single_group();
    logic [15:0] mac;
    do_reset();
    send_beat(8'h03, 1'b0); send_beat(8'h05, 1'b0); send_beat(8'h02, 1'b0); send_beat(8'h04, 1'b1);
    checks++; if (valids() !== 4'b1111) begin failures++; $display("FAIL t1_valids got=%b exp=1111", valids()); end
    checks++; if (datas() !== 32'h03050204) begin failures++; $display("FAIL t1_data got=%h exp=03050204", datas()); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL t1_s_ready_issue got=%b exp=0", s_ready); end
    mac = (16'(m_a_data) + 16'(m_b_data)) * (16'(m_c_data) + 16'(m_d_data));
    checks++; if (mac !== 16'h0030) begin failures++; $display("FAIL t1_mac got=%h exp=0030", mac); end
    @(negedge clk);
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t1_valids_drop got=%b exp=0000", valids()); end
    checks++; if (grp_count !== 8'd1) begin failures++; $display("FAIL t1_grp got=%0d exp=1", grp_count); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL t1_s_ready_back got=%b exp=1", s_ready); end
  endtask

  task automatic test_b_backpressure();
    do_reset();
    m_b_ready = 1'b0;
    send_beat(8'h03, 1'b0); send_beat(8'h05, 1'b0); send_beat(8'h02, 1'b0); send_beat(8'h04, 1'b1);
    checks++; if (valids() !== 4'b1111) begin failures++; $display("FAIL t2_valids got=%b exp=1111", valids()); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (valids() !== 4'b0100) begin failures++; $display("FAIL t2_b_only c%0d got=%b exp=0100", k, valids()); end
      checks++; if (m_b_data !== 8'h05) begin failures++; $display("FAIL t2_b_hold c%0d got=%h exp=05", k, m_b_data); end
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL t2_s_ready c%0d got=%b exp=0", k, s_ready); end
    end
    m_b_ready = 1'b1;
    @(negedge clk);
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t2_valids_drop got=%b exp=0000", valids()); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL t2_s_ready_back got=%b exp=1", s_ready); end
    checks++; if (grp_count !== 8'd1) begin failures++; $display("FAIL t2_grp got=%0d exp=1", grp_count); end
  endtask

  task automatic test_early_last();
    do_reset();
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b1);
    checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL t3_err got=%b exp=1", err_framing); end
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t3_no_valids got=%b exp=0000", valids()); end
    @(negedge clk);
    checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL t3_err_pulse got=%b exp=0", err_framing); end
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0); send_beat(8'h33, 1'b0); send_beat(8'h44, 1'b1);
    checks++; if (valids() !== 4'b1111) begin failures++; $display("FAIL t3_valids got=%b exp=1111", valids()); end
    checks++; if (datas() !== 32'h11223344) begin failures++; $display("FAIL t3_data got=%h exp=11223344", datas()); end
    checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL t3_err_issue got=%b exp=0", err_framing); end
    @(negedge clk);
    checks++; if (grp_count !== 8'd1) begin failures++; $display("FAIL t3_grp got=%0d exp=1", grp_count); end
  endtask

  task automatic test_missing_last();
    do_reset();
    send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0); send_beat(8'h03, 1'b0); send_beat(8'h04, 1'b0);
    checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL t4_err got=%b exp=1", err_framing); end
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t4_no_valids got=%b exp=0000", valids()); end
    checks++; if (grp_count !== 8'd0) begin failures++; $display("FAIL t4_grp_kept got=%0d exp=0", grp_count); end
    @(negedge clk);
    checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL t4_err_pulse got=%b exp=0", err_framing); end
    send_beat(8'h55, 1'b1);
    checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL t4_err_first got=%b exp=1", err_framing); end
    send_beat(8'h66, 1'b1);
    checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL t4_err_second got=%b exp=1", err_framing); end
    @(negedge clk);
    checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL t4_err_end got=%b exp=0", err_framing); end
    send_beat(8'h0A, 1'b0); send_beat(8'h0B, 1'b0); send_beat(8'h0C, 1'b0); send_beat(8'h0D, 1'b1);
    checks++; if (datas() !== 32'h0A0B0C0D) begin failures++; $display("FAIL t4_realign got=%h exp=0a0b0c0d", datas()); end
    checks++; if (valids() !== 4'b1111) begin failures++; $display("FAIL t4_valids got=%b exp=1111", valids()); end
    @(negedge clk);
    checks++; if (grp_count !== 8'd1) begin failures++; $display("FAIL t4_grp got=%0d exp=1", grp_count); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    {m_a_ready, m_b_ready, m_c_ready, m_d_ready} = 4'b0000;
    send_beat(8'h12, 1'b0); send_beat(8'h34, 1'b0); send_beat(8'h56, 1'b0); send_beat(8'h78, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (valids() !== 4'b1111) begin failures++; $display("FAIL t5_valids_held got=%b exp=1111", valids()); end
    checks++; if (datas() !== 32'h12345678) begin failures++; $display("FAIL t5_data_held got=%h exp=12345678", datas()); end
    rst = 1'b1;
    #1;
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t5_valids_async got=%b exp=0000", valids()); end
    checks++; if (grp_count !== 8'd0) begin failures++; $display("FAIL t5_grp got=%0d exp=0", grp_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL t5_s_ready got=%b exp=1", s_ready); end
    checks++; if (valids() !== 4'b0000) begin failures++; $display("FAIL t5_valids_after got=%b exp=0000", valids()); end
    {m_a_ready, m_b_ready, m_c_ready, m_d_ready} = 4'b1111;
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = cyc;
    for (int g = 0; g < 256; g++) begin
      send_beat(8'(g), 1'b0); send_beat(8'(g + 1), 1'b0);
      send_beat(8'(g + 2), 1'b0); send_beat(8'(g + 3), 1'b1);
    end
    checks++; if (datas() !== 32'hFF000102) begin failures++; $display("FAIL t6_last_data got=%h exp=ff000102", datas()); end
    checks++; if (grp_count !== 8'd255) begin failures++; $display("FAIL t6_grp_255 got=%0d exp=255", grp_count); end
    @(negedge clk);
    checks++; if (grp_count !== 8'd0) begin failures++; $display("FAIL t6_grp_wrap got=%0d exp=0", grp_count); end
    checks++; if (cyc - c0 !== 1280) begin failures++; $display("FAIL t6_cycles got=%0d exp=1280", cyc - c0); end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_b_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid_issue();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cycles=%0d limit=200000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
